// File: rtl/bullet_controller.sv
// bullet_controller: one player's projectile. Launches from the shooter on a
// fire edge, advances once per video frame, retires off-screen or on a hit,
// then holds off new shots for a number of frames.
// Optional feature macro: BULLET_GRAVITY_EN (ballistic vertical motion).
module bullet_controller #(
    parameter int STEP            = 4,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic       facing_left,
    input  logic [9:0] ShooterX,
    input  logic [9:0] ShooterY,
    input  logic       hit,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic [9:0] bullet_on,
    output logic       ready
);

    typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

    state_t     state, state_next;
    logic [9:0] bullet_x, bullet_y, x_next, y_next;
    logic       dir, dir_next;
    logic [7:0] cnt, cnt_next;
    logic       on_q, ready_q;

    logic frame_s1, frame_s2, frame_d, tick;
    logic fire_d, fire_rise;

    logic [10:0] x_fwd;
    logic [9:0]  x_back;
    logic        x_out, y_out;

`ifdef BULLET_GRAVITY_EN
    logic signed [4:0]  vy, vy_next;
    logic signed [10:0] y_sum;
`endif

    // Synchronize the frame strobe and remember fire for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_s1 <= 1'b0;
            frame_s2 <= 1'b0;
            frame_d  <= 1'b0;
            fire_d   <= 1'b0;
        end else begin
            frame_s1 <= frame_clk;
            frame_s2 <= frame_s1;
            frame_d  <= frame_s2;
            fire_d   <= fire;
        end
    end

    assign tick      = frame_s2 & ~frame_d;
    assign fire_rise = fire & ~fire_d;

    // Horizontal move candidates; the forward sum is one bit wider so it
    // cannot wrap past X_MAX.
    assign x_fwd  = {1'b0, bullet_x} + 11'(STEP);
    assign x_back = bullet_x - 10'(STEP);
    assign x_out  = dir ? (bullet_x < 10'(STEP)) : (x_fwd > 11'(X_MAX));

`ifdef BULLET_GRAVITY_EN
    assign y_sum = $signed({1'b0, bullet_y}) + {{6{vy[4]}}, vy};
    assign y_out = (y_sum < 11'sd0) || (y_sum > $signed(11'(Y_MAX)));
`else
    assign y_out = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state and datapath next values.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        x_next     = bullet_x;
        y_next     = bullet_y;
        dir_next   = dir;
        cnt_next   = cnt;
`ifdef BULLET_GRAVITY_EN
        vy_next    = vy;
`endif
        case (state)
            IDLE: begin
                if (fire_rise) begin
                    state_next = FLYING;
                    x_next     = ShooterX;
                    y_next     = ShooterY;
                    dir_next   = facing_left;
`ifdef BULLET_GRAVITY_EN
                    vy_next    = -5'sd4;
`endif
                end
            end
            FLYING: begin
                if (hit) begin
                    // A hit wins over a coincident tick: no movement applied.
                    state_next = COOLDOWN;
                    cnt_next   = 8'(COOLDOWN_FRAMES);
                end else if (tick) begin
                    if (x_out || y_out) begin
                        state_next = COOLDOWN;
                        cnt_next   = 8'(COOLDOWN_FRAMES);
                    end else begin
                        x_next = dir ? x_back : x_fwd[9:0];
`ifdef BULLET_GRAVITY_EN
                        y_next  = y_sum[9:0];
                        vy_next = (vy == 5'sd7) ? 5'sd7 : vy + 5'sd1;
`endif
                    end
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    cnt_next = cnt - 8'd1;
                    if (cnt == 8'd1) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bullet_x <= '0;
            bullet_y <= '0;
            dir      <= 1'b0;
            cnt      <= '0;
            on_q     <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            bullet_x <= x_next;
            bullet_y <= y_next;
            dir      <= dir_next;
            cnt      <= cnt_next;
            on_q     <= (state_next == FLYING);
            ready_q  <= (state_next == IDLE);
        end
    end

`ifdef BULLET_GRAVITY_EN
    // Vertical velocity register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) vy <= '0;
        else          vy <= vy_next;
    end
`endif

    assign BulletX   = bullet_x;
    assign BulletY   = bullet_y;
    assign bullet_on = {9'b0, on_q};
    assign ready     = ready_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed testbench for bullet_controller. Inputs change on the falling
// clock edge; outputs are sampled on the falling edge after the effect.
// Honours BULLET_GRAVITY_EN when the design is built with it.
`timescale 1ns/1ps
module tb_bullet_controller;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic       fire;
    logic       facing_left;
    logic [9:0] ShooterX;
    logic [9:0] ShooterY;
    logic       hit;
    logic [9:0] BulletX;
    logic [9:0] BulletY;
    logic [9:0] bullet_on;
    logic       ready;

    int checks = 0;
    int errors = 0;

    bullet_controller dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .fire       (fire),
        .facing_left(facing_left),
        .ShooterX   (ShooterX),
        .ShooterY   (ShooterY),
        .hit        (hit),
        .BulletX    (BulletX),
        .BulletY    (BulletY),
        .bullet_on  (bullet_on),
        .ready      (ready)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One frame strobe; the tick is consumed on the third rising edge.
    task automatic frame_tick();
        frame_clk = 1'b1;
        step(3);
        frame_clk = 1'b0;
        step(3);
    endtask

    task automatic ticks(input int n);
        repeat (n) frame_tick();
    endtask

    // Hit asserted in exactly the cycle in which the tick is consumed.
    task automatic hit_with_tick();
        frame_clk = 1'b1;
        step(2);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        frame_clk = 1'b0;
        step(3);
    endtask

    // Produce a rising fire edge; fire is left high.
    task automatic launch(input logic [9:0] sx, input logic [9:0] sy, input logic left);
        ShooterX    = sx;
        ShooterY    = sy;
        facing_left = left;
        fire        = 1'b0;
        step(1);
        check("pre_launch_on", 16'(bullet_on), 16'd0);
        fire = 1'b1;
        step(1);
    endtask

    logic [9:0] y_tbl [6];

    initial begin
        y_tbl[0] = 10'd196; y_tbl[1] = 10'd193; y_tbl[2] = 10'd191;
        y_tbl[3] = 10'd190; y_tbl[4] = 10'd190; y_tbl[5] = 10'd191;

        Reset_n = 1'b0; frame_clk = 1'b0; fire = 1'b0; facing_left = 1'b0;
        ShooterX = 10'd0; ShooterY = 10'd0; hit = 1'b0;
        step(3);
        check("rst_x", 16'(BulletX), 16'd0);
        check("rst_y", 16'(BulletY), 16'd0);
        check("rst_on", 16'(bullet_on), 16'd0);
        check("rst_ready", 16'(ready), 16'd1);
        Reset_n = 1'b1;
        step(2);

        // Hit while idle is ignored.
        hit = 1'b1; step(1); hit = 1'b0; step(1);
        check("idle_hit_ready", 16'(ready), 16'd1);
        check("idle_hit_on", 16'(bullet_on), 16'd0);

        // Launch right from (100,200), one cycle latency.
        launch(10'd100, 10'd200, 1'b0);
        fire = 1'b0;
        check("l1_on", 16'(bullet_on), 16'd1);
        check("l1_x", 16'(BulletX), 16'd100);
        check("l1_y", 16'(BulletY), 16'd200);
        check("l1_ready", 16'(ready), 16'd0);
        ShooterX = 10'd500; ShooterY = 10'd17;
        for (int i = 0; i < 6; i++) begin
            frame_tick();
            check("l1_fly_x", 16'(BulletX), 16'(100 + 4 * (i + 1)));
`ifdef BULLET_GRAVITY_EN
            check("l1_fly_y", 16'(BulletY), 16'(y_tbl[i]));
`else
            check("l1_fly_y", 16'(BulletY), 16'd200);
`endif
        end
        hit = 1'b1; step(1); hit = 1'b0;
        check("l1_hit_on", 16'(bullet_on), 16'd0);
        check("l1_hit_x", 16'(BulletX), 16'd124);
        ticks(7);
        check("l1_cool7_ready", 16'(ready), 16'd0);
        ticks(1);
        check("l1_cool8_ready", 16'(ready), 16'd1);

        // Right edge: 630 -> 634 -> 638 -> retire.
        launch(10'd630, 10'd200, 1'b0);
        fire = 1'b0;
        frame_tick(); check("r_t1_x", 16'(BulletX), 16'd634);
        frame_tick(); check("r_t2_x", 16'(BulletX), 16'd638);
        check("r_t2_on", 16'(bullet_on), 16'd1);
        frame_tick();
        check("r_t3_on", 16'(bullet_on), 16'd0);
        check("r_t3_x", 16'(BulletX), 16'd638);
        check("r_t3_ready", 16'(ready), 16'd0);
        ticks(7); check("r_cool7_ready", 16'(ready), 16'd0);
        ticks(1); check("r_cool8_ready", 16'(ready), 16'd1);

        // Left edge: 6 -> 2 -> retire.
        launch(10'd6, 10'd200, 1'b1);
        fire = 1'b0;
        frame_tick(); check("l_t1_x", 16'(BulletX), 16'd2);
        check("l_t1_on", 16'(bullet_on), 16'd1);
        frame_tick();
        check("l_t2_on", 16'(bullet_on), 16'd0);
        check("l_t2_x", 16'(BulletX), 16'd2);
        ticks(8); check("l_cool_ready", 16'(ready), 16'd1);

        // Held fire, re-fire while flying, then hit with coincident tick at 300.
        launch(10'd296, 10'd200, 1'b0);
        frame_tick(); check("h_x300", 16'(BulletX), 16'd300);
        ShooterX = 10'd50;
        fire = 1'b0; step(2); fire = 1'b1; step(2);
        check("h_refire_x", 16'(BulletX), 16'd300);
        check("h_refire_on", 16'(bullet_on), 16'd1);
        hit_with_tick();
        check("h_hit_on", 16'(bullet_on), 16'd0);
        check("h_hit_x", 16'(BulletX), 16'd300);
        ticks(8); check("h_cool_ready", 16'(ready), 16'd1);
        ticks(12);
        check("h_held_on", 16'(bullet_on), 16'd0);
        check("h_held_ready", 16'(ready), 16'd1);
        fire = 1'b0; step(2); fire = 1'b1; step(1);
        check("h_new_on", 16'(bullet_on), 16'd1);
        check("h_new_x", 16'(BulletX), 16'd50);

        // Asynchronous reset mid-flight.
        frame_tick(); check("m_x", 16'(BulletX), 16'd54);
        #2 Reset_n = 1'b0;
        #1;
        check("m_rst_x", 16'(BulletX), 16'd0);
        check("m_rst_y", 16'(BulletY), 16'd0);
        check("m_rst_on", 16'(bullet_on), 16'd0);
        check("m_rst_ready", 16'(ready), 16'd1);
        fire = 1'b0;
        step(2);
        Reset_n = 1'b1;
        step(2);

`ifdef BULLET_GRAVITY_EN
        // Low launch falls past the bottom row on the 11th tick.
        launch(10'd100, 10'd470, 1'b0);
        fire = 1'b0;
        ticks(10);
        check("g_t10_y", 16'(BulletY), 16'd475);
        check("g_t10_on", 16'(bullet_on), 16'd1);
        frame_tick();
        check("g_t11_on", 16'(bullet_on), 16'd0);
        check("g_t11_y", 16'(BulletY), 16'd475);
        check("g_t11_x", 16'(BulletX), 16'd140);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bullet_controller.md
Name: bullet_controller

Overview:
- Per-player bullet state machine that sits directly upstream of the color mapper.
- Produces BulletX, BulletY and bullet_on for one player's projectile.
- Launches the bullet from the shooter's position on a fire request and advances it once per video frame.
- Retires the bullet when it leaves the screen or hits a target, then enforces a cooldown before the next shot. Two instances are used: player 1 and player 2.

Parameters:
- STEP, 4, horizontal pixels moved per frame tick (1..15).
- X_MAX, 639, rightmost valid pixel column.
- Y_MAX, 479, bottom valid pixel row.
- COOLDOWN_FRAMES, 8, frame ticks in COOLDOWN before a new shot is accepted (1..255).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous active-low reset.
- frame_clk  in  1  vsync-rate frame strobe, asynchronous level, sampled on Clk.
- fire  in  1  fire request level; one shot per rising edge.
- facing_left  in  1  shooter direction at launch (1 = move toward X = 0).
- ShooterX  in  10  shooter centre X.
- ShooterY  in  10  shooter centre Y.
- hit  in  1  one-Clk pulse from collision logic; retires an active bullet.
- BulletX  out  10  bullet centre X.
- BulletY  out  10  bullet centre Y.
- bullet_on  out  10  bullet visible; bit 0 = flying, bits 9:1 = 0 (matches consumer width).
- ready  out  1  1 when IDLE (shot would be accepted).

Behaviour:
- Reset (async, Reset_n = 0): state IDLE, BulletX = 0, BulletY = 0, bullet_on = 0, ready = 1, cooldown counter = 0, edge registers cleared.
- Frame tick: frame_clk passes through a 2-flop synchronizer; tick = sync & ~sync_d. Exactly one Clk-wide tick per frame_clk rising edge.
- Fire edge: fire is registered; fire_rise = fire & ~fire_d. Holding fire high gives exactly one shot.
- States: IDLE, FLYING, COOLDOWN.
- IDLE:
  - On fire_rise, latch BulletX = ShooterX, BulletY = ShooterY and dir = facing_left in the same edge.
  - Next cycle: state FLYING, bullet_on = 1, ready = 0. Latency from fire_rise to bullet_on is 1 Clk.
- FLYING, per tick:
  - Moving right: if BulletX + STEP > X_MAX (computed 11-bit, no wrap), go to COOLDOWN; else BulletX += STEP.
  - Moving left: if BulletX < STEP, go to COOLDOWN; else BulletX -= STEP.
  - Position is never wrapped or clamped; the bullet retires instead.
  - hit = 1 in FLYING goes to COOLDOWN on the next edge. hit has priority over a simultaneous tick, and no movement is applied.
  - fire_rise in FLYING or COOLDOWN is ignored (not queued).
- Entering COOLDOWN: bullet_on = 0. BulletX/BulletY keep their last value. Counter loads COOLDOWN_FRAMES.
- COOLDOWN: each tick decrements the counter. When a tick arrives with counter = 1, go to IDLE and set ready = 1.
- hit outside FLYING: ignored.
- Shooter inputs: ShooterX/ShooterY changes after launch do not affect the bullet.
- Reset mid-flight: immediately clears everything to reset values. No tick or fire is remembered across reset.
- Output timing: all outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro BULLET_GRAVITY_EN.
- Defined:
  - A signed 5-bit vertical velocity vy is set to -4 at launch.
  - In FLYING, each tick: BulletY += vy (signed; computed 11-bit), then vy increments by 1, saturating at +7.
  - Retire to COOLDOWN if the result is < 0 or > Y_MAX, evaluated in the same tick as the X bound. Either bound retiring causes no position update.
- Not defined: BulletY is constant at its launch value, vy logic is absent, and there is no Y bound check.

Test Plan:
- Reset, then fire_rise with ShooterX = 100, ShooterY = 200, facing_left = 0, STEP = 4 -> 1 Clk later bullet_on = 1, BulletX = 100, BulletY = 200, ready = 0. After 3 ticks BulletX = 112.
- Launch at X = 630 moving right -> tick 1: X = 634; tick 2: X = 638; tick 3 (642 > 639): bullet_on = 0, X stays 638, COOLDOWN. Exactly 8 further ticks -> ready = 1.
- Launch at X = 6 moving left -> tick 1: X = 2; tick 2 (2 < 4): retire, X = 2, bullet_on = 0.
- fire held high 20 frames, plus a second fire_rise during FLYING -> exactly one bullet. After cooldown, no new shot until fire falls and rises again.
- hit and tick in the same Clk while FLYING at X = 300 -> bullet_on = 0 next edge, X stays 300. Reset_n pulsed low mid-flight -> outputs 0 and ready = 1 asynchronously.
- BULLET_GRAVITY_EN defined, launch Y = 200 -> Y after ticks: 196, 193, 191, 190, 190, 191. Launch Y = 470 -> retires when Y would exceed 479.
